// File: rtl/host_pkt_arbiter.sv
// host_pkt_arbiter: packet-atomic round-robin arbiter merging NUM_PORTS FWFT packet FIFOs onto one host stream
//   clk_host, rst_n (sync, active-low)
//   req_valid/req_data/req_rd_en : per-port FIFO head word and pop strobe
//   out_valid/out_data/out_port/out_ready : registered output beat with backpressure
//   err_orphan/err_abort : one-cycle pulses for dropped non-sop heads and watchdog aborts
//   HOST_ARB_PKT_CNT_EN : adds pkt_cnt, per-port count of completed packets
module host_pkt_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int WORD_W = 77,
  parameter int MAX_PKT_BEATS = 256
) (
  input  logic                          clk_host,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*WORD_W-1:0]   req_data,
  output logic [NUM_PORTS-1:0]          req_rd_en,
  output logic                          out_valid,
  output logic [WORD_W-1:0]             out_data,
  output logic [$clog2(NUM_PORTS)-1:0]  out_port,
  input  logic                          out_ready,
  output logic                          err_orphan,
  output logic                          err_abort
`ifdef HOST_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]       pkt_cnt
`endif
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_PKT_BEATS + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, rr_nx, grant, grant_nx, cand, sel, idx;
  logic [CW-1:0] beat_cnt, beat_nx;
  logic [WORD_W-1:0] head;
  logic found, space, load, orphan, abort, head_sop, head_eop;
  // lowest offset from rr_ptr wins, so scan offsets from the far end down
  always_comb begin
    cand = '0;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_PORTS);
      if (req_valid[idx]) begin
        found = 1'b1;
        cand = idx;
      end
    end
  end
  always_comb begin
    space = !out_valid || out_ready;
    sel = state == LOCKED ? grant : cand;
    head = req_data[sel*WORD_W +: WORD_W];
    head_sop = head[65];
    head_eop = head[64];
    // orphans are discarded without touching the output register, so space is irrelevant
    orphan = state == IDLE && found && !head_sop;
    load = space && (state == LOCKED ? req_valid[grant] : found && head_sop);
    req_rd_en = rst_n && (load || orphan) ? NUM_PORTS'(1) << sel : '0;
    abort = state == LOCKED && load && !head_eop && beat_cnt >= CW'(MAX_PKT_BEATS - 1);
    state_nx = state;
    rr_nx = rr_ptr;
    grant_nx = grant;
    beat_nx = beat_cnt;
    if (load && state == IDLE) begin
      rr_nx = PW'((int'(cand) + 1) % NUM_PORTS);
      grant_nx = cand;
      beat_nx = CW'(1);
      state_nx = head_eop ? IDLE : LOCKED;
    end else if (load) begin
      beat_nx = beat_cnt == CW'(MAX_PKT_BEATS) ? beat_cnt : beat_cnt + 1'b1;
      state_nx = head_eop || abort ? IDLE : LOCKED;
    end
  end
  always_ff @(posedge clk_host) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      beat_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_port <= '0;
      err_orphan <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      state <= state_nx;
      rr_ptr <= rr_nx;
      grant <= grant_nx;
      beat_cnt <= beat_nx;
      out_valid <= load || (out_valid && !out_ready);
      if (load) begin
        out_data <= head;
        out_port <= sel;
      end
      err_orphan <= orphan;
      err_abort <= abort;
    end
  end
`ifdef HOST_ARB_PKT_CNT_EN
  always_ff @(posedge clk_host) begin
    if (!rst_n)
      pkt_cnt <= '0;
    else
      for (int i = 0; i < NUM_PORTS; i++)
        if (load && head_eop && sel == PW'(i))
          pkt_cnt[i*32 +: 32] <= pkt_cnt[i*32 +: 32] + 32'd1;
  end
`endif
endmodule

// File: tb/tb_host_pkt_arbiter.sv
// tb_host_pkt_arbiter: directed scoreboard bench for host_pkt_arbiter
module tb_host_pkt_arbiter;
  localparam int NP = 4;
  localparam int W = 77;
  logic clk_host = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0] req_valid = '0;
  logic [NP*W-1:0] req_data = '0;
  logic [NP-1:0] req_rd_en;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [1:0] out_port;
  logic out_ready = 1'b1;
  logic err_orphan, err_abort;
`ifdef HOST_ARB_PKT_CNT_EN
  logic [NP*32-1:0] pkt_cnt;
`endif
  host_pkt_arbiter #(.NUM_PORTS(NP), .WORD_W(W), .MAX_PKT_BEATS(4)) dut (
    .clk_host(clk_host),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_rd_en(req_rd_en),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_port(out_port),
    .out_ready(out_ready),
    .err_orphan(err_orphan),
    .err_abort(err_abort)
`ifdef HOST_ARB_PKT_CNT_EN
    ,
    .pkt_cnt(pkt_cnt)
`endif
  );
  always #5 clk_host = ~clk_host;
  logic [W-1:0] fq [NP][$];
  logic [W+1:0] exq [$];
  int checks = 0, errors = 0, seq = 0, orph = 0, abrt = 0;
  logic [NP-1:0] s_rd;
  logic s_ov, s_or;
  logic [W-1:0] s_od;
  logic [1:0] s_op;
  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      req_valid[i] = fq[i].size() > 0;
      req_data[i*W +: W] = fq[i].size() > 0 ? fq[i][0] : '0;
    end
  endtask
  function automatic bit busy();
    busy = 1'b0;
    for (int i = 0; i < NP; i++) if (fq[i].size() > 0) busy = 1'b1;
  endfunction
  task automatic send_pkt(input int p, input int n, input int nfwd, input bit s, input bit e);
    logic [W-1:0] w;
    for (int k = 0; k < n; k++) begin
      seq++;
      w = {8'(p), 3'(k), s && k == 0, e && k == n - 1, 64'hA500_0000_0000_0000 | 64'(seq)};
      fq[p].push_back(w);
      if (k < nfwd) exq.push_back({2'(p), w});
    end
  endtask
  // one clock: sample before the edge, apply pops and check the beat after it
  task automatic cyc();
    logic [W+1:0] e;
    drive();
    #1;
    s_rd = req_rd_en;
    s_ov = out_valid;
    s_or = out_ready;
    s_od = out_data;
    s_op = out_port;
    @(posedge clk_host);
    #1;
    for (int i = 0; i < NP; i++) if (s_rd[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    drive();
    orph += int'(err_orphan);
    abrt += int'(err_abort);
    if (s_ov && s_or) begin
      if (exq.size() == 0) chk("sb_extra", 128'(exq.size()), 128'(1));
      else begin
        e = exq.pop_front();
        chk("sb_beat", 128'({s_op, s_od}), 128'(e));
      end
    end
  endtask
  task automatic drain(input int maxc);
    int c = 0;
    while ((exq.size() > 0 || busy()) && c < maxc) begin
      cyc();
      c++;
    end
    chk("drain_done", 128'(exq.size() == 0 && !busy()), 128'(1));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask
  initial begin
    int o0, a0;
    logic [W-1:0] hold;
    do_reset();
    chk("rst_ov", 128'(out_valid), 128'(0));
    chk("rst_od", 128'(out_data), 128'(0));
    chk("rst_op", 128'(out_port), 128'(0));
    chk("rst_eo", 128'(err_orphan), 128'(0));
    chk("rst_ea", 128'(err_abort), 128'(0));
    // T1: single 3-beat packet on port 1
    send_pkt(1, 3, 3, 1, 1);
    cyc();
    chk("t1_rd", 128'(s_rd), 128'(4'b0010));
    chk("t1_ov_pre", 128'(s_ov), 128'(0));
    chk("t1_lat", 128'(out_valid), 128'(1));
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t1_ov", 128'(s_ov), 128'(1));
    end
    chk("t1_end", 128'(out_valid), 128'(0));
    // T2: round robin over ports 0,2,3 from rr_ptr=0
    do_reset();
    for (int r = 0; r < 2; r++) begin
      send_pkt(0, 2, 2, 1, 1);
      send_pkt(2, 2, 2, 1, 1);
      send_pkt(3, 2, 2, 1, 1);
    end
    drain(60);
    // T3: backpressure mid-packet
    send_pkt(1, 3, 3, 1, 1);
    hold = exq[0][W-1:0];
    cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t3_rd", 128'(s_rd), 128'(0));
      chk("t3_hold", 128'(s_od), 128'(hold));
    end
    out_ready = 1'b1;
    drain(20);
    // T4: orphan head on port 0
    send_pkt(0, 1, 0, 0, 1);
    o0 = orph;
    cyc();
    chk("t4_rd", 128'(s_rd), 128'(4'b0001));
    chk("t4_orph", 128'(err_orphan), 128'(1));
    chk("t4_ov", 128'(out_valid), 128'(0));
    cyc();
    chk("t4_pulse", 128'(err_orphan), 128'(0));
    chk("t4_cnt", 128'(orph - o0), 128'(1));
    // T5: watchdog abort at 4 beats, two trailing orphans
    o0 = orph;
    a0 = abrt;
    send_pkt(2, 6, 4, 1, 0);
    drain(40);
    chk("t5_abort", 128'(abrt - a0), 128'(1));
    chk("t5_orph", 128'(orph - o0), 128'(2));
    // T6: reset mid-packet
    send_pkt(0, 3, 0, 1, 1);
    out_ready = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("t6_rd", 128'(s_rd), 128'(0));
    chk("t6_ov", 128'(out_valid), 128'(0));
`ifdef HOST_ARB_PKT_CNT_EN
    chk("t6_cnt0", 128'(pkt_cnt), 128'(0));
`endif
    rst_n = 1'b1;
    out_ready = 1'b1;
    o0 = orph;
    drain(20);
    chk("t6_orph", 128'(orph - o0), 128'(2));
    send_pkt(0, 2, 2, 1, 1);
    send_pkt(0, 2, 2, 1, 1);
    drain(20);
`ifdef HOST_ARB_PKT_CNT_EN
    chk("t6_cnt2", 128'(pkt_cnt), 128'(32'd2));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
